// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array operand feeder: FSM encoding,
// default array geometry and the drain-length rule.
package systolic_feeder_pkg;

  // Default array geometry (rows = columns = lanes) and operand width.
  localparam int ARR_N  = 4;
  localparam int ARR_DW = 8;

  // Tile sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } fsm_state_e;

  // Cycles to wait after the last read until PE(N-1,N-1) holds its final sum:
  // 2*(n-1) cycles of array skew plus 2 cycles of buffer and edge latency.
  function automatic int drain_len(input int n);
    return 2 * (n - 1) + 2;
  endfunction

  localparam int DRAIN_LEN = drain_len(ARR_N);

endpackage

// File: rtl/systolic_feeder_skew_line.sv
// One lane of the edge skew: an edge register that zeroes data whenever the
// valid is low, followed by DEPTH further stages carrying data and valid
// together. DEPTH = 0 leaves just the edge register.
module systolic_feeder_skew_line #(
  parameter int W     = 8,
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         v_i,
  input  logic [W-1:0] d_i,
  output logic         v_o,
  output logic [W-1:0] d_o
);

  logic [DEPTH:0]        v_q;
  logic [DEPTH:0][W-1:0] d_q;

  // Edge register plus shift line; data is forced to zero at entry when invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      d_q <= '0;
    end else begin
      v_q[0] <= v_i;
      d_q[0] <= v_i ? d_i : {W{1'b0}};
      for (int s = 1; s <= DEPTH; s++) begin
        v_q[s] <= v_q[s-1];
        d_q[s] <= d_q[s-1];
      end
    end
  end

  assign v_o = v_q[DEPTH];
  assign d_o = d_q[DEPTH];

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N systolic array. Reads one A column and one B
// row per cycle, skews lane i by i cycles on both edges, pulses clr before
// each tile and pulses done when PE(N-1,N-1) holds its final sum.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int DW_ = ARR_DW,
  parameter int N_  = ARR_N,
  parameter int KW_ = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KW_-1:0]    k_len,
  output logic              rd_en,
  output logic [KW_-1:0]    rd_addr,
  input  logic [N_*DW_-1:0] a_rd_data,
  input  logic [N_*DW_-1:0] b_rd_data,
  output logic [N_*DW_-1:0] a_edge,
  output logic [N_-1:0]     a_edge_v,
  output logic [N_*DW_-1:0] b_edge,
  output logic [N_-1:0]     b_edge_v,
  output logic              clr,
  output logic              busy,
  output logic              done
);

  localparam int DRAIN_CYC = drain_len(N_);
  localparam int DCW       = $clog2(DRAIN_CYC + 1);

  fsm_state_e     state_q, state_d;
  logic [KW_-1:0] k_q, k_d;
  logic [KW_-1:0] addr_q, addr_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           rd_v_q;

  // State, latched depth and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Next-state and counter sequencing for one tile.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
          k_d     = k_len;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        addr_d = '0;
        dcnt_d = '0;
        if (k_q != {KW_{1'b0}}) begin
          state_d = ST_STREAM;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_STREAM: begin
        if (addr_q == k_q - KW_'(1)) begin
          state_d = ST_DRAIN;
        end else begin
          addr_d = addr_q + KW_'(1);
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == DCW'(DRAIN_CYC - 1)) begin
          state_d = ST_DONE;
        end else begin
          dcnt_d = dcnt_q + DCW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control outputs decoded from the registered state.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    clr     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr  = 1'b1;
        busy = 1'b1;
      end
      ST_STREAM: begin
        rd_en   = 1'b1;
        rd_addr = addr_q;
        busy    = 1'b1;
      end
      ST_DRAIN: begin
        busy = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Marks the cycle in which buffer read data is present (one after rd_en).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v_q <= 1'b0;
    end else begin
      rd_v_q <= rd_en;
    end
  end

  // Both edges share rd_v_q, so a_edge_v and b_edge_v are identical per lane.
  for (genvar i = 0; i < N_; i++) begin : g_lane
    systolic_feeder_skew_line #(.W(DW_), .DEPTH(i)) u_a_line (
      .clk (clk),
      .rst (rst),
      .v_i (rd_v_q),
      .d_i (a_rd_data[i*DW_ +: DW_]),
      .v_o (a_edge_v[i]),
      .d_o (a_edge[i*DW_ +: DW_])
    );
    systolic_feeder_skew_line #(.W(DW_), .DEPTH(i)) u_b_line (
      .clk (clk),
      .rst (rst),
      .v_i (rd_v_q),
      .d_i (b_rd_data[i*DW_ +: DW_]),
      .v_o (b_edge_v[i]),
      .d_o (b_edge[i*DW_ +: DW_])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: directed tiles from the test plan
// plus random back-to-back tiles, checked against a cycle-numbered timing
// model and a matrix-product reference computed from the operand arrays.
module tb_systolic_feeder;

  localparam int DW   = 8;
  localparam int N    = 4;
  localparam int KW   = 8;
  localparam int MAXC = 300;
  localparam int KMAX = 256;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            rd_en;
  logic [KW-1:0]   rd_addr;
  logic [N*DW-1:0] a_rd_data, b_rd_data, a_edge, b_edge;
  logic [N-1:0]    a_edge_v, b_edge_v;
  logic            clr, busy, done;

  systolic_feeder #(.DW_(DW), .N_(N), .KW_(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
    .a_edge(a_edge), .a_edge_v(a_edge_v),
    .b_edge(b_edge), .b_edge_v(b_edge_v),
    .clr(clr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Operand matrices: A is N x K, B is K x N (signed values).
  int A [N][KMAX];
  int B [KMAX][N];

  // Observed trace, indexed by cycle number relative to start acceptance.
  logic            o_clr [MAXC];
  logic            o_rd  [MAXC];
  logic            o_busy[MAXC];
  logic            o_done[MAXC];
  logic [KW-1:0]   o_addr[MAXC];
  logic [N-1:0]    o_av  [MAXC];
  logic [N-1:0]    o_bv  [MAXC];
  logic [N*DW-1:0] o_a   [MAXC];
  logic [N*DW-1:0] o_b   [MAXC];

  // Array result rebuilt from the observed edges, and PE(N-1,N-1) last-MAC cycle.
  int c_obs [N][N];
  int last33;

  // Timing model: {clr, rd_en, busy, done} expected in cycle t of a K-deep tile.
  function automatic logic [3:0] exp_ctrl(input int t, input int k);
    int dc;
    dc = (k == 0) ? 2 : k + 4 + 2 * (N - 1);
    return {t == 1, (k > 0) && (t >= 2) && (t <= k + 1), (t >= 1) && (t <= dc), t == dc};
  endfunction

  // Lane l carries operand k in cycle k + 4 + l.
  function automatic bit exp_v(input int t, input int l, input int k);
    return (t >= l + 4) && (t <= k + 3 + l);
  endfunction

  // Reference product C = A * B over depth k.
  function automatic int golden(input int i, input int j, input int k);
    int s;
    s = 0;
    for (int q = 0; q < k; q++) s += A[i][q] * B[q][j];
    return s;
  endfunction

  // Behaves like the PE grid: PE(i,j) sees row i delayed j and column j delayed i.
  function automatic void array_from_trace(input int ncyc);
    int ta, tb, sa, sb;
    last33 = -1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) c_obs[i][j] = 0;
    for (int t = 0; t < ncyc; t++)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          ta = t - j;
          tb = t - i;
          if (ta >= 0 && tb >= 0 && o_av[ta][i] && o_bv[tb][j]) begin
            sa = int'($signed(o_a[ta][i*DW +: DW]));
            sb = int'($signed(o_b[tb][j*DW +: DW]));
            c_obs[i][j] += sa * sb;
            if (i == N - 1 && j == N - 1) last33 = t;
          end
        end
  endfunction

  // Stimulus: issue start now (cycle 0), record ncyc cycles, serve buffer reads
  // with one cycle latency and drive junk on the buffer when no read is pending.
  task automatic run_tile(input int k, input int ncyc, input int restart_at);
    logic          pr;
    logic [KW-1:0] pa;
    start = 1'b1;
    k_len = KW'(k);
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      o_clr[t] = clr;  o_rd[t] = rd_en;  o_busy[t] = busy;  o_done[t] = done;
      o_addr[t] = rd_addr;
      o_av[t] = a_edge_v;  o_bv[t] = b_edge_v;  o_a[t] = a_edge;  o_b[t] = b_edge;
      pr = rd_en;
      pa = rd_addr;
      @(posedge clk);
      #1;
      start = (t + 1 == restart_at);
      k_len = KW'($urandom_range(1, 200));
      for (int i = 0; i < N; i++) begin
        a_rd_data[i*DW +: DW] = pr ? DW'(A[i][int'(pa)]) : DW'($urandom);
        b_rd_data[i*DW +: DW] = pr ? DW'(B[int'(pa)][i]) : DW'($urandom);
      end
    end
    start = 1'b0;
  endtask

  task automatic randomize_operands(input int k);
    for (int q = 0; q < k; q++)
      for (int i = 0; i < N; i++) begin
        A[i][q] = $urandom_range(0, 255) - 128;
        B[q][i] = $urandom_range(0, 255) - 128;
      end
  endtask

  task automatic test_reset();
    rst = 1'b1;  start = 1'b0;  k_len = '0;
    a_rd_data = '0;  b_rd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({rd_en, rd_addr, a_edge, a_edge_v, b_edge, b_edge_v, clr, busy, done} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got busy=%b clr=%b done=%b rd_en=%b av=%b", busy, clr, done, rd_en, a_edge_v);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_stream();
    start = 1'b1;  k_len = 8'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;  // cycle 5: streaming, lane 0 already valid
    n_cmp++;
    if ({busy, rd_en, a_edge_v[0]} !== 3'b111) begin
      n_bad++;
      $display("FAIL midrst_pre got busy/rd_en/av0=%b want 111", {busy, rd_en, a_edge_v[0]});
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({rd_en, rd_addr, a_edge, a_edge_v, b_edge, b_edge_v, clr, busy, done} !== '0) begin
      n_bad++;
      $display("FAIL midrst_async got busy=%b rd_en=%b av=%b bv=%b", busy, rd_en, a_edge_v, b_edge_v);
    end
    #1 rst = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      n_cmp++;
      if ({rd_en, clr, busy, done, a_edge_v, b_edge_v} !== '0) begin
        n_bad++;
        $display("FAIL midrst_quiet t=%0d got rd/clr/busy/done=%b%b%b%b av=%b want 0", t, rd_en, clr, busy, done, a_edge_v);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_k4();
    for (int q = 0; q < 4; q++)
      for (int i = 0; i < N; i++) begin
        A[i][q] = (i == q) ? 1 : 0;
        B[q][i] = q * 4 + i + 1;
      end
    run_tile(4, 15, 0);
    for (int t = 0; t < 15; t++) begin
      n_cmp++;
      if ({o_clr[t], o_rd[t], o_busy[t], o_done[t]} !== {t == 1, t >= 2 && t <= 5, t >= 1 && t <= 14, t == 14}) begin
        n_bad++;
        $display("FAIL basic_ctrl t=%0d got clr/rd/busy/done=%b%b%b%b", t, o_clr[t], o_rd[t], o_busy[t], o_done[t]);
      end
      if (t >= 2 && t <= 5) begin
        n_cmp++;
        if (o_addr[t] !== KW'(t - 2)) begin
          n_bad++;
          $display("FAIL basic_addr t=%0d got %0d want %0d", t, o_addr[t], t - 2);
        end
      end
      n_cmp++;
      if ({o_av[t][0], o_av[t][3], o_bv[t]} !== {t >= 4 && t <= 7, t >= 7 && t <= 10, o_av[t]}) begin
        n_bad++;
        $display("FAIL basic_valid t=%0d got av=%b bv=%b", t, o_av[t], o_bv[t]);
      end
    end
    array_from_trace(15);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        n_cmp++;
        if (c_obs[i][j] != i * 4 + j + 1) begin
          n_bad++;
          $display("FAIL basic_C[%0d][%0d] got %0d want %0d", i, j, c_obs[i][j], i * 4 + j + 1);
        end
      end
    n_cmp++;
    if (last33 != 13) begin
      n_bad++;
      $display("FAIL basic_last_mac got cycle %0d want 13", last33);
    end
  endtask

  task automatic test_k0();
    run_tile(0, 3, 0);
    for (int t = 0; t < 3; t++) begin
      n_cmp++;
      if ({o_clr[t], o_rd[t], o_busy[t], o_done[t], o_av[t], o_bv[t]} !== {t == 1, 1'b0, t >= 1, t == 2, 8'h00}) begin
        n_bad++;
        $display("FAIL k0 t=%0d got clr/rd/busy/done=%b%b%b%b av=%b bv=%b", t, o_clr[t], o_rd[t], o_busy[t], o_done[t], o_av[t], o_bv[t]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    randomize_operands(4);
    run_tile(4, 15, 6);
    for (int t = 0; t < 15; t++) begin
      n_cmp++;
      if ({o_busy[t], o_done[t]} !== {t >= 1, t == 14}) begin
        n_bad++;
        $display("FAIL busystart_t1 t=%0d got busy/done=%b%b", t, o_busy[t], o_done[t]);
      end
    end
    randomize_operands(4);
    run_tile(4, 15, 0);
    for (int t = 0; t < 15; t++) begin
      n_cmp++;
      if ({o_clr[t], o_rd[t], o_busy[t], o_done[t]} !== exp_ctrl(t, 4)) begin
        n_bad++;
        $display("FAIL busystart_t2 t=%0d got %b want %b", t, {o_clr[t], o_rd[t], o_busy[t], o_done[t]}, exp_ctrl(t, 4));
      end
    end
    array_from_trace(15);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        n_cmp++;
        if (c_obs[i][j] != golden(i, j, 4)) begin
          n_bad++;
          $display("FAIL busystart_C[%0d][%0d] got %0d want %0d", i, j, c_obs[i][j], golden(i, j, 4));
        end
      end
  endtask

  task automatic test_max_k();
    int cnt_a, cnt_b, first, ndone, bad_data;
    for (int q = 0; q < 255; q++)
      for (int i = 0; i < N; i++) begin
        A[i][q] = -128;
        B[q][i] = 127;
      end
    run_tile(255, 266, 0);
    for (int l = 0; l < N; l++) begin
      cnt_a = 0;  cnt_b = 0;  first = -1;  bad_data = 0;
      for (int t = 0; t < 266; t++) begin
        if (o_av[t][l]) cnt_a++;
        if (o_bv[t][l]) cnt_b++;
        if (o_av[t][l] && first < 0) first = t;
        if (o_a[t][l*DW +: DW] !== (o_av[t][l] ? 8'h80 : 8'h00)) bad_data++;
        if (o_b[t][l*DW +: DW] !== (o_bv[t][l] ? 8'h7f : 8'h00)) bad_data++;
      end
      n_cmp++;
      if (cnt_a != 255 || cnt_b != 255 || first != l + 4) begin
        n_bad++;
        $display("FAIL maxk_lane%0d got cnt_a=%0d cnt_b=%0d first=%0d want 255 255 %0d", l, cnt_a, cnt_b, first, l + 4);
      end
      n_cmp++;
      if (bad_data != 0) begin
        n_bad++;
        $display("FAIL maxk_data lane%0d got %0d bad cycles want 0", l, bad_data);
      end
    end
    ndone = 0;
    for (int t = 0; t < 266; t++) if (o_done[t]) ndone++;
    n_cmp++;
    if (ndone != 1 || o_done[265] !== 1'b1) begin
      n_bad++;
      $display("FAIL maxk_done got count=%0d done@265=%b want 1 1", ndone, o_done[265]);
    end
    array_from_trace(266);
    n_cmp++;
    if (c_obs[N-1][N-1] != 255 * (-128) * 127 || c_obs[0][0] != 255 * (-128) * 127) begin
      n_bad++;
      $display("FAIL maxk_C got %0d/%0d want %0d", c_obs[0][0], c_obs[N-1][N-1], 255 * (-128) * 127);
    end
  endtask

  task automatic test_back_to_back();
    int k, idx;
    logic [DW-1:0] ea, eb;
    bit ev;
    for (int tile = 0; tile < 6; tile++) begin
      k = $urandom_range(1, 16);
      randomize_operands(k);
      run_tile(k, k + 11, 0);
      for (int t = 0; t < k + 11; t++) begin
        n_cmp++;
        if ({o_clr[t], o_rd[t], o_busy[t], o_done[t]} !== exp_ctrl(t, k)) begin
          n_bad++;
          $display("FAIL b2b_ctrl k=%0d t=%0d got %b want %b", k, t, {o_clr[t], o_rd[t], o_busy[t], o_done[t]}, exp_ctrl(t, k));
        end
        if (exp_ctrl(t, k) & 4'b0100) begin
          n_cmp++;
          if (o_addr[t] !== KW'(t - 2)) begin
            n_bad++;
            $display("FAIL b2b_addr k=%0d t=%0d got %0d want %0d", k, t, o_addr[t], t - 2);
          end
        end
        n_cmp++;
        if (o_av[t] !== o_bv[t]) begin
          n_bad++;
          $display("FAIL b2b_vmatch k=%0d t=%0d got av=%b bv=%b", k, t, o_av[t], o_bv[t]);
        end
        for (int l = 0; l < N; l++) begin
          ev = exp_v(t, l, k);
          ea = '0;
          eb = '0;
          if (ev) begin
            idx = t - 4 - l;
            ea = DW'(A[l][idx]);
            eb = DW'(B[idx][l]);
          end
          n_cmp++;
          if ({o_av[t][l], o_a[t][l*DW +: DW], o_b[t][l*DW +: DW]} !== {ev, ea, eb}) begin
            n_bad++;
            $display("FAIL b2b_lane%0d k=%0d t=%0d got v=%b a=%h b=%h want v=%b a=%h b=%h", l, k, t, o_av[t][l], o_a[t][l*DW +: DW], o_b[t][l*DW +: DW], ev, ea, eb);
          end
        end
      end
      array_from_trace(k + 11);
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          n_cmp++;
          if (c_obs[i][j] != golden(i, j, k)) begin
            n_bad++;
            $display("FAIL b2b_C[%0d][%0d] k=%0d got %0d want %0d", i, j, k, c_obs[i][j], golden(i, j, k));
          end
        end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_stream();
    test_basic_k4();
    test_k0();
    test_start_while_busy();
    test_max_k();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Operand transmitter for the 4x4 systolic array: drives the west (A-row) and north (B-column) edges that the processing elements consume.
- Reads one A column and one B row per cycle from the tile operand buffers and applies the diagonal skew: row i / column j are delayed i / j cycles.
- Drives the array-wide clr pulse before each tile and signals done once PE(N-1,N-1) holds its final sum.

Parameters:
DW_, 8, operand width (signed two's complement)
N_, 4, array dimension (rows = columns = lanes)
KW_, 8, width of k_len and rd_addr; max reduction depth 2^KW_-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to run one tile; sampled only in IDLE
k_len  in  KW_  reduction depth K; latched when start is accepted
rd_en  out  1  operand buffer read strobe
rd_addr  out  KW_  k index read this cycle
a_rd_data  in  N_*DW_  A[i][k] for all i, lane i at bits [i*DW_ +: DW_]; valid the cycle after rd_en
b_rd_data  in  N_*DW_  B[k][j] for all j, same packing and timing
a_edge  out  N_*DW_  skewed west-edge data, lane i to row i
a_edge_v  out  N_  west-edge valid per row
b_edge  out  N_*DW_  skewed north-edge data, lane j to column j
b_edge_v  out  N_  north-edge valid per column
clr  out  1  accumulator clear to all PEs
busy  out  1  tile in progress
done  out  1  one-cycle pulse: array results final

Behaviour:
- Reset (async, any state): FSM to IDLE; all outputs 0; all skew registers and counters cleared. A tile in flight is abandoned and emits no done.
- States:
  - IDLE: start=1 latches k_len into K, goes to CLEAR. start while not IDLE is ignored.
  - CLEAR: clr=1 for exactly one cycle, no reads. Next state is STREAM if K>0, else DONE.
  - STREAM: rd_en=1 with rd_addr = 0,1,...,K-1 on consecutive cycles. Goes to DRAIN after addr K-1 is issued.
  - DRAIN: counts 2*(N_-1)+2 cycles, then DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Timing, with the start-accept edge ending cycle 0:
  - clr is high in cycle 1.
  - Reads are issued in cycles 2..K+1.
  - Buffer latency is 1 cycle; the edge registers add 1 more, so read k issued in cycle c appears on row 0 / column 0 in cycle c+2, and on lane i in cycle c+2+i.
  - PE(N-1,N-1) accumulates its last product at the end of cycle K+3+2(N_-1); done is asserted in cycle K+4+2(N_-1).
  - K=0: done in cycle 2, and no valid is ever raised.
- busy is high from cycle 1 through the done cycle inclusive. It is low in IDLE, including the cycle start is sampled.
- Each lane is a shift line of depth i carrying data and valid together. Data is forced to 0 whenever its valid is 0.
- a_edge_v[i] and b_edge_v[i] are always identical in the same cycle. Skew for both edges is derived from the same rd_en pipeline.
- Valids of consecutive k are contiguous, with no bubbles in a lane.
- The block does no arithmetic. Sizing the PE accumulator to absorb K products of 2*DW_ bits is the array's responsibility.
- Back-to-back tiles: start is accepted in the cycle after done. clr of the next tile cannot overlap valids of the previous one, because all lanes are empty by DONE.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, CLEAR, STREAM, DRAIN, DONE.
  - Array constants: N_, DW_.
  - Drain length constant: 2*(N_-1)+2.
- One sub-module, skew_line, parameterised by width and depth, with depth 0 = pass-through of the edge register. Instantiated per lane for A and B (2*N_ instances).

Test Plan:
- rst asserted mid-STREAM (K=8, cycle 5) -> all outputs 0 in the same cycle; after release no done and no valid until a new start.
- N=4, K=4; A = identity, B[k][j] = k*4+j+1 -> clr cycle 1 only; rd_addr 0..3 in cycles 2..5; a_edge_v[0] high cycles 4..7; a_edge_v[3] high cycles 7..10; done in cycle 14; reference array model C = B.
- K=0 -> clr cycle 1, done cycle 2, rd_en never high, all edge valids 0; busy high cycles 1..2.
- start pulsed while busy (cycle 6 of a K=4 tile) -> ignored, single done at cycle 14; start in cycle 15 -> clr in cycle 16.
- A = all -128, B = all 127, K=255 -> edge lanes carry 0x80/0x7F with correct skew and 255 contiguous valids per lane; done at cycle 255+4+6=265.
- Random back-to-back tiles (K in 1..16, random operands) -> checker confirms: per-lane skew of exactly i cycles, data 0 whenever valid 0, a_edge_v == b_edge_v every cycle, and array result matches golden matrix product.
